// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: FSM states, program
// select encoding, program base addresses and branch-label indices.
package fetch_pkg;

    localparam int PC_W  = 8;
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] SEL_PROD = 2'd0;
    localparam logic [1:0] SEL_STR  = 2'd1;
    localparam logic [1:0] SEL_PAIR = 2'd2;
    localparam logic [1:0] SEL_RSVD = 2'd3;

    localparam logic [PC_W-1:0] PROD_BASE = 8'd0;
    localparam logic [PC_W-1:0] STR_BASE  = 8'd28;
    localparam logic [PC_W-1:0] PAIR_BASE = 8'd48;

    localparam logic [IDX_W-1:0] LBL_PROD_LOOP      = 4'd0;
    localparam logic [IDX_W-1:0] LBL_PROD_SHIFT     = 4'd1;
    localparam logic [IDX_W-1:0] LBL_PROD_LOWERLOOP = 4'd2;
    localparam logic [IDX_W-1:0] LBL_STR_LOOP       = 4'd3;
    localparam logic [IDX_W-1:0] LBL_STR_MATCHLOOP  = 4'd4;
    localparam logic [IDX_W-1:0] LBL_STR_FOUND      = 4'd5;
    localparam logic [IDX_W-1:0] LBL_STR_INCJ       = 4'd6;
    localparam logic [IDX_W-1:0] LBL_PAIR_OUTER     = 4'd7;
    localparam logic [IDX_W-1:0] LBL_PAIR_INNER     = 4'd8;
    localparam logic [IDX_W-1:0] LBL_PAIR_IJSUB     = 4'd9;
    localparam logic [IDX_W-1:0] LBL_PAIR_COMPDIST  = 4'd10;
    localparam logic [IDX_W-1:0] LBL_PAIR_INCJ      = 4'd11;

    function automatic logic [PC_W-1:0] prog_base(input logic [1:0] sel);
        case (sel)
            SEL_PROD: return PROD_BASE;
            SEL_STR:  return STR_BASE;
            SEL_PAIR: return PAIR_BASE;
            default:  return PROD_BASE;
        endcase
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Control/fetch bundle between decode/execute and the fetch sequencer.
// master = fetch_ctrl side, slave = decode/imem side.
interface fetch_if;
    import fetch_pkg::*;

    logic                 Start;
    logic [1:0]           ProgSel;
    logic                 Stall;
    logic                 Halt;
    logic                 BranchEn;
    logic [IDX_W-1:0]     BranchIdx;
    logic [PC_W-1:0]      PC;
    logic                 PCValid;
    logic                 Busy;
    logic                 Done;
    logic [15:0]          CycleCount;

    modport master (
        input  Start, ProgSel, Stall, Halt, BranchEn, BranchIdx,
        output PC, PCValid, Busy, Done, CycleCount
    );

    modport slave (
        output Start, ProgSel, Stall, Halt, BranchEn, BranchIdx,
        input  PC, PCValid, Busy, Done, CycleCount
    );

endinterface

// File: rtl/fetch_ctrl_branch_lut.sv
// Combinational label-index -> branch-target table for the three resident
// programs; indices with no label return hit=0.
module branch_lut
    import fetch_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic             hit,
    output logic [PC_W-1:0]  target
);

    // label decode
    always_comb begin
        hit    = 1'b1;
        target = 8'd0;
        case (idx)
            LBL_PROD_LOOP:      target = 8'd2;
            LBL_PROD_SHIFT:     target = 8'd8;
            LBL_PROD_LOWERLOOP: target = 8'd23;
            LBL_STR_LOOP:       target = 8'd28;
            LBL_STR_MATCHLOOP:  target = 8'd32;
            LBL_STR_FOUND:      target = 8'd42;
            LBL_STR_INCJ:       target = 8'd43;
            LBL_PAIR_OUTER:     target = 8'd50;
            LBL_PAIR_INNER:     target = 8'd52;
            LBL_PAIR_IJSUB:     target = 8'd57;
            LBL_PAIR_COMPDIST:  target = 8'd58;
            LBL_PAIR_INCJ:      target = 8'd61;
            default: begin
                hit    = 1'b0;
                target = 8'd0;
            end
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// PC / fetch sequencer: launches a resident program, follows branches and
// stalls, and pulses Done on halt. Optional run-cycle counter under
// FETCH_CYCLE_COUNT_EN.
module fetch_ctrl
    import fetch_pkg::*;
(
    input  logic     Clk,
    input  logic     Reset_n,
    fetch_if.master  bus
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]      state_r, state_s;
    logic [PC_W-1:0] pc_r, pc_s;
    logic            pc_valid_r, busy_r, done_r;
    logic            start_accept_s;
    logic            hit_s;
    logic [PC_W-1:0] target_s;

    branch_lut u_lut (
        .idx    (bus.BranchIdx),
        .hit    (hit_s),
        .target (target_s)
    );

    assign start_accept_s = (state_r == S_IDLE) && bus.Start && (bus.ProgSel != SEL_RSVD);

    // next-state / next-PC; Stall outranks Halt outranks BranchEn
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        case (state_r)
            S_IDLE: begin
                if (start_accept_s) begin
                    state_s = S_RUN;
                    pc_s    = prog_base(bus.ProgSel);
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (bus.Stall) begin
                    pc_s = pc_r;
                end else if (bus.Halt) begin
                    state_s = S_DONE;
                end else if (bus.BranchEn && hit_s) begin
                    pc_s = target_s;
                end else begin
                    pc_s = pc_r + PC_W'(1);
                end
            end
            S_DONE: state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // state, PC and status flops; status is registered from next state
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r    <= S_IDLE;
            pc_r       <= 8'd0;
            pc_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            pc_valid_r <= (state_s == S_RUN);
            busy_r     <= (state_s == S_RUN);
            done_r     <= (state_s == S_DONE);
        end
    end

    assign bus.PC      = pc_r;
    assign bus.PCValid = pc_valid_r;
    assign bus.Busy    = busy_r;
    assign bus.Done    = done_r;

`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0] cycle_count_r;

    // saturating RUN-cycle counter, stalls included, cleared on launch
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            cycle_count_r <= 16'd0;
        end else if (start_accept_s) begin
            cycle_count_r <= 16'd0;
        end else if ((state_r == S_RUN) && (cycle_count_r != 16'hFFFF)) begin
            cycle_count_r <= cycle_count_r + 16'd1;
        end else begin
            cycle_count_r <= cycle_count_r;
        end
    end

    assign bus.CycleCount = cycle_count_r;
`else
    assign bus.CycleCount = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a behavioural model pushes the expected
// outputs each cycle, which are popped and compared after the clock edge.
module tb_fetch_ctrl;

    logic Clk;
    logic Reset_n;

    fetch_if bus ();

    fetch_ctrl dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct packed {
        logic [7:0]  pc;
        logic        valid;
        logic        busy;
        logic        done;
        logic [15:0] cc;
    } exp_t;

    exp_t sb[$];

    int n_total = 0;
    int n_bad   = 0;

    int          m_state = 0;  // 0 idle, 1 run, 2 done
    logic [7:0]  m_pc    = 8'd0;
    logic [15:0] m_cc    = 16'd0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [8:0] lut(input logic [3:0] i);
        case (i)
            4'd0:  return {1'b1, 8'd2};
            4'd1:  return {1'b1, 8'd8};
            4'd2:  return {1'b1, 8'd23};
            4'd3:  return {1'b1, 8'd28};
            4'd4:  return {1'b1, 8'd32};
            4'd5:  return {1'b1, 8'd42};
            4'd6:  return {1'b1, 8'd43};
            4'd7:  return {1'b1, 8'd50};
            4'd8:  return {1'b1, 8'd52};
            4'd9:  return {1'b1, 8'd57};
            4'd10: return {1'b1, 8'd58};
            4'd11: return {1'b1, 8'd61};
            default: return 9'd0;
        endcase
    endfunction

    task automatic cyc(input logic rst, input logic st, input logic [1:0] sel,
                       input logic stl, input logic hlt, input logic ben, input logic [3:0] idx);
        exp_t e;
        logic [8:0] l;
        Reset_n       = rst;
        bus.Start     = st;
        bus.ProgSel   = sel;
        bus.Stall     = stl;
        bus.Halt      = hlt;
        bus.BranchEn  = ben;
        bus.BranchIdx = idx;
        if (!rst) begin
            m_state = 0; m_pc = 8'd0; m_cc = 16'd0;
        end else begin
            case (m_state)
                0: if (st && sel != 2'd3) begin
                    m_state = 1;
                    m_cc    = 16'd0;
                    m_pc    = (sel == 2'd0) ? 8'd0 : (sel == 2'd1) ? 8'd28 : 8'd48;
                end
                1: begin
                    if (m_cc != 16'hFFFF) m_cc = m_cc + 16'd1;
                    l = lut(idx);
                    if (stl) ;
                    else if (hlt) m_state = 2;
                    else if (ben && l[8]) m_pc = l[7:0];
                    else m_pc = m_pc + 8'd1;
                end
                default: m_state = 0;
            endcase
        end
        e.pc    = m_pc;
        e.valid = (m_state == 1);
        e.busy  = (m_state == 1);
        e.done  = (m_state == 2);
`ifdef FETCH_CYCLE_COUNT_EN
        e.cc    = m_cc;
`else
        e.cc    = 16'd0;
`endif
        sb.push_back(e);
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        check_val("pc",    32'(bus.PC),         32'(e.pc));
        check_val("valid", 32'(bus.PCValid),    32'(e.valid));
        check_val("busy",  32'(bus.Busy),       32'(e.busy));
        check_val("done",  32'(bus.Done),       32'(e.done));
        check_val("cc",    32'(bus.CycleCount), 32'(e.cc));
    endtask

    task automatic plain(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic start(input logic [1:0] sel);
        cyc(1'b1, 1'b1, sel, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic halt_and_finish();
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0);
        check_val("done_pulse", 32'(bus.Done), 32'd1);
        cyc(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);  // Start during DONE ignored
        check_val("done_clear", 32'(bus.Done), 32'd0);
        check_val("idle_busy",  32'(bus.Busy), 32'd0);
    endtask

    initial begin
        Reset_n = 1'b0;
        bus.Start = 1'b0; bus.ProgSel = 2'd0; bus.Stall = 1'b0;
        bus.Halt = 1'b0; bus.BranchEn = 1'b0; bus.BranchIdx = 4'd0;

        cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        check_val("rst_pc", 32'(bus.PC), 32'd0);

        // reset mid-run at PC=14
        start(2'd0);
        plain(14);
        check_val("pre_rst_pc", 32'(bus.PC), 32'd14);
        cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        check_val("mid_rst_pc",    32'(bus.PC),      32'd0);
        check_val("mid_rst_valid", 32'(bus.PCValid), 32'd0);
        check_val("mid_rst_busy",  32'(bus.Busy),    32'd0);
        check_val("mid_rst_done",  32'(bus.Done),    32'd0);
        plain(1);

        // string match: 28..31, halt at 47
        start(2'd1);
        check_val("str_pc0", 32'(bus.PC), 32'd28);
        for (int i = 1; i < 4; i++) begin
            plain(1);
            check_val("str_seq", 32'(bus.PC), 32'(28 + i));
        end
        plain(16);
        check_val("str_pc47", 32'(bus.PC), 32'd47);
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0);
        check_val("str_done", 32'(bus.Done), 32'd1);
        check_val("str_busy", 32'(bus.Busy), 32'd0);
        check_val("str_hold", 32'(bus.PC),   32'd47);
        plain(2);
        check_val("str_idle_pc", 32'(bus.PC), 32'd47);

        // product: branch idx 0 at 16 -> 2, idx 13 at 5 -> 6
        start(2'd0);
        plain(16);
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'd0);
        check_val("br_loop", 32'(bus.PC), 32'd2);
        plain(3);
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'd13);
        check_val("br_unmapped", 32'(bus.PC), 32'd6);
        halt_and_finish();

        // closest pair: stall 3 cycles at 50 with Halt/BranchEn, then branch 8
        start(2'd2);
        plain(2);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 4'd8);
            check_val("stall_hold", 32'(bus.PC), 32'd50);
        end
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'd8);
        check_val("br_inner", 32'(bus.PC), 32'd52);
        halt_and_finish();

        // reserved select ignored
        start(2'd3);
        check_val("rsvd_valid", 32'(bus.PCValid), 32'd0);
        check_val("rsvd_pc",    32'(bus.PC),      32'd52);

        // full label sweep, each followed by a plain increment
        start(2'd0);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'(i));
            plain(1);
        end
        halt_and_finish();

        // Start during RUN is ignored; run up to 255 and wrap
        start(2'd0);
        start(2'd2);
        check_val("start_in_run", 32'(bus.PC), 32'd1);
        for (int i = 0; i < 300 && bus.PC != 8'd255; i++) plain(1);
        check_val("pc255", 32'(bus.PC), 32'd255);
        plain(1);
        check_val("wrap", 32'(bus.PC), 32'd0);
        halt_and_finish();

        // cycle counter: 7 plain + 2 stall + halt = 10 RUN cycles
        start(2'd1);
        plain(7);
        cyc(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        cyc(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0);
`ifdef FETCH_CYCLE_COUNT_EN
        check_val("cc_ten", 32'(bus.CycleCount), 32'd10);
`else
        check_val("cc_tied", 32'(bus.CycleCount), 32'd0);
`endif
        plain(1);
        start(2'd0);
        check_val("cc_clear", 32'(bus.CycleCount), 32'd0);
        halt_and_finish();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Program-counter and fetch sequencer that drives the 8-bit PC into instruction memory and advances it each cycle. Launches one of three resident programs (product, string match, closest pair) on a Start pulse. Applies taken branches through an internal label-target table, honours stalls, and reports completion when decode flags the done instruction. Sits directly upstream of instruction memory; decode/execute feed its control inputs back.

## Interface
- PC_W, 8, PC width; also instruction memory address width
- IDX_W, 4, branch-label index width
- Clk  in  1  single clock, all state on rising edge
- Reset_n  in  1  synchronous, active-low reset
- Start  in  1  launch request, sampled in IDLE only
- ProgSel  in  2  program select: 0 product, 1 string match, 2 closest pair, 3 reserved
- Stall  in  1  hold PC this cycle
- Halt  in  1  decode: the instruction at current PC is done
- BranchEn  in  1  decode/execute: branch at current PC is taken
- BranchIdx  in  IDX_W  label index of the taken branch
- PC  out  PC_W  fetch address to instruction memory
- PCValid  out  1  PC is a live fetch address
- Busy  out  1  program running
- Done  out  1  one-cycle completion pulse
- CycleCount  out  16  run-cycle counter (see Configuration)

## Operation
- States: IDLE, RUN, DONE.
- IDLE: PC holds, PCValid=0, Busy=0. Start=1 and ProgSel!=3 -> PC<=base, state RUN. Bases: 0, 28, 48. Start with ProgSel=3 is ignored.
- RUN: PCValid=1, Busy=1. Priority per cycle: Stall > Halt > BranchEn > increment.
  - Stall: PC and state hold. Halt and BranchEn are ignored that cycle.
  - Halt: state DONE, PC holds.
  - BranchEn: PC<=target[BranchIdx].
  - Otherwise: PC<=PC+1, modulo 2^PC_W, so 255 wraps to 0 with no flag.
- Start is ignored in RUN and DONE.
- DONE: Done=1, Busy=0, PCValid=0 for exactly one cycle, then IDLE. PC keeps the halt address until the next launch.
- Target table:
  - Product: 0:2 (loop), 1:8 (shift), 2:23 (lowerloop)
  - String match: 3:28 (stringLoop), 4:32 (matchLoop), 5:42 (found), 6:43 (incJ)
  - Closest pair: 7:50 (outer), 8:52 (inner), 9:57 (ijSub), 10:58 (compDist), 11:61 (incJ)
  - Indices 12-15 are unmapped; a taken branch to one of them falls through to PC+1.
- Reset_n=0 at any edge, including mid-RUN: state IDLE, PC=0, PCValid=0, Busy=0, Done=0, CycleCount=0. Any in-flight program is abandoned.

## Timing
- All outputs are registered or decoded from registered state only. No combinational path from inputs to outputs.
- Start accepted at edge N -> PC=base and PCValid=1 from cycle N+1.
- Halt, BranchEn and Stall are evaluated against the PC presented in the same cycle; the next PC appears after one edge.
- Halt accepted at edge N -> Done high during cycle N+1 -> IDLE at N+2. The earliest relaunch is a Start sampled at edge N+2.
- No branch delay slot; a taken branch redirects on the next cycle.

## Configuration
- FETCH_CYCLE_COUNT_EN defined:
  - CycleCount increments on every RUN cycle, stalled cycles included.
  - It clears to 0 on Start acceptance and saturates at 0xFFFF.
  - It holds its value through DONE and IDLE.
- Undefined: CycleCount is tied to 0 and no counter flops are built.

## Structure
- Package fetch_pkg holds:
  - the state enum {IDLE, RUN, DONE}
  - the program base constants PROD_BASE=0, STR_BASE=28, PAIR_BASE=48
  - the ProgSel encoding
  - the label index constants
- Sub-module branch_lut holds the combinational BranchIdx -> {hit, target} table. Unmapped indices return hit=0.

## Test plan
- Reset_n low for 2 cycles mid-RUN at PC=14 -> next cycle IDLE, PC=0, PCValid=0, Busy=0, Done=0.
- Start with ProgSel=1 -> PC sequence 28, 29, 30, 31. Assert Halt at PC=47 -> Done high exactly one cycle, Busy low, PC stays 47.
- ProgSel=0 run; BranchEn with BranchIdx=0 at PC=16 -> next PC=2. BranchIdx=13 at PC=5 -> next PC=6.
- Stall held 3 cycles at PC=50 with BranchEn=1 and Halt=1 -> PC holds 50 for 3 cycles. After release with BranchEn=1, BranchIdx=8 -> PC=52.
- Start with ProgSel=3 -> stays IDLE. Start during RUN -> PC sequence undisturbed. Run until PC=255 with no branch -> PC wraps to 0.
- With FETCH_CYCLE_COUNT_EN: Start, 10 run cycles including 2 stalls, then Halt -> CycleCount=10 after Done. Next Start clears it to 0.
